// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit: the FSM state
// enumeration, the opcodes the controller recognises, and the encodings of
// every datapath select it drives (ALU operation, immediate format, result
// mux, ALU operand muxes, and the internal ALUOp class handed to the ALU
// decoder). Also provides the opcode-only immediate format lookup.
package mc_ctrl_pkg;

  // Controller states, one per step of the multicycle instruction walk
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_BRANCH,
    S_LUI,
    S_TRAP
  } state_t;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  // ALU operand A selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B selects
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format depends only on the opcode so the extender can settle
  // as soon as the IR is loaded, independent of which state we are in.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:           imm = IMM_S;
      OP_BRANCH:          imm = IMM_B;
      OP_JAL:             imm = IMM_J;
      OP_LUI, OP_AUIPC:   imm = IMM_U;
      default:            imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec
// Combinational ALU decoder. The FSM supplies an operation class; for the
// funct class the RV32I funct3/funct7b5 fields pick the exact operation.
// Ports:
//   aluop      in  2  operation class: 00 add, 01 sub, 10 funct decode
//   funct3     in  3  IR funct3
//   op5        in  1  IR opcode bit 5 (distinguishes R-type from I-type)
//   funct7b5   in  1  IR bit 30
//   alucontrol out 4  ALU operation select
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [3:0] alucontrol
);

  // Bit 30 only means "subtract" for register-register ops; for addi it is
  // just an immediate bit, hence the op5 qualifier. For shifts it selects
  // arithmetic in both formats.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Moore-style multicycle control unit for an RV32I core with a single shared
// memory port. Walks each instruction through fetch, decode, execute, memory
// and writeback states, stalling memory states until MemReady. Illegal or
// disabled encodings land in a sticky TRAP state that only reset leaves.
// Parameters:
//   EN_BRANCH_EXT  1 = BNE/BLT/BGE/BLTU/BGEU legal, 0 = they trap
//   EN_UPPER       1 = LUI/AUIPC legal, 0 = they trap
// Ports:
//   clk, reset               clock, async active-high reset
//   op, funct3, funct7b5     instruction fields from the IR
//   Zero, Neg, Ovf, Carry    ALU flags of a-b (Carry = carry-out of a+~b+1)
//   MemReady                 memory finishes the current access this cycle
//   MemReq, MemWrite         memory request and store strobe
//   IRWrite, PCWrite         IR and PC load enables
//   AdrSrc                   memory address: 0 PC, 1 Result
//   ALUSrcA, ALUSrcB         ALU operand selects
//   ResultSrc                result mux select
//   ImmSrc                   immediate format (opcode only)
//   ALUControl               ALU operation
//   RegWrite                 register file write enable
//   IllegalInstr             high while trapped
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_BRANCH_EXT = 1'b1,
  parameter bit EN_UPPER      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  input  logic       Ovf,
  input  logic       Carry,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  state_t     state;
  state_t     decode_target;
  logic       taken;
  logic       branch_legal;
  logic [1:0] aluop;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;

  // Branch condition from the flags of rs1 - rs2. Signed less-than is
  // Neg^Ovf; unsigned less-than is the absence of a carry out of the
  // subtraction (i.e. a borrow occurred).
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Neg ^ Ovf;
      3'b101:  taken = ~(Neg ^ Ovf);
      3'b110:  taken = ~Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  // BEQ is always available; the other five only when the extension is
  // enabled. funct3 010/011 are unassigned and never legal.
  assign branch_legal = (funct3 == 3'b000) ||
                        (EN_BRANCH_EXT && ((funct3 == 3'b001) || funct3[2]));

  // Where DECODE goes next. Anything not explicitly recognised as legal
  // falls through to TRAP, so new encodings are safe by default.
  always_comb begin
    decode_target = S_TRAP;
    case (op)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) decode_target = S_MEMADR;
      OP_RTYPE:          decode_target = S_EXECR;
      OP_ITYPE:          decode_target = S_EXECI;
      OP_BRANCH:         if (branch_legal) decode_target = S_BRANCH;
      OP_JAL:            decode_target = S_JAL;
      OP_JALR:           if (funct3 == 3'b000) decode_target = S_JALR;
      OP_LUI:            if (EN_UPPER) decode_target = S_LUI;
      OP_AUIPC:          if (EN_UPPER) decode_target = S_ALUWB;
      default:           decode_target = S_TRAP;
    endcase
  end

  // State register and transition rules. Memory states hold until the
  // memory reports ready; TRAP is absorbing. JALR reuses the JAL state to
  // write the link address, so the computed target must be in ALUOut by
  // then (which the JALR state arranges).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE:   state <= decode_target;
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JALR:     state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        S_LUI:      state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls. Everything defaults to zero/add so each
  // state only names what it actually uses. The strobes are collected in
  // internal signals so they can be squashed while reset is held.
  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    IllegalInstr = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    aluop        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = MemReady;
        pc_write  = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_RS2;
        aluop    = ALUOP_SUB;
        pc_write = taken;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        reg_write = 1'b1;
      end
      S_TRAP: begin
        IllegalInstr = 1'b1;
      end
      default: begin
        IllegalInstr = 1'b0;
      end
    endcase
  end

  // Reset is asynchronous, so the state snaps to FETCH immediately, but
  // FETCH itself requests memory; gating here guarantees no access or write
  // strobe is visible for as long as reset is held.
  assign MemReq   = mem_req   & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign PCWrite  = pc_write  & ~reset;
  assign RegWrite = reg_write & ~reset;

  assign ImmSrc = imm_src_of(op);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Self-checking bench for mc_controller. Two instances share one stimulus
// stream: the default build and a build with branch extensions and upper
// immediates disabled. Each instruction is expanded into the list of steps
// it must take, and every cycle's outputs are compared against the values
// those steps call for. Branch flags come from real operand pairs, and the
// expected branch outcome is taken from a direct comparison of the operands.
module tb_mc_controller;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_BAD = 9;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3;
  localparam int P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7;
  localparam int P_ALUWB = 8, P_JALR = 9, P_JAL = 10, P_BRANCH = 11;
  localparam int P_LUI = 12, P_TRAP = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, Neg, Ovf, Carry;
  logic       MemReady;

  logic       MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, IllegalInstr;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  logic       n_memreq, n_memwrite, n_irwrite, n_pcwrite, n_adrsrc, n_regwrite, n_illegal;
  logic [1:0] n_srca, n_srcb, n_ressrc;
  logic [2:0] n_immsrc;
  logic [3:0] n_aluctl;

  logic [16:0] obs_a, obs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .IllegalInstr(IllegalInstr)
  );

  mc_controller #(.EN_BRANCH_EXT(1'b0), .EN_UPPER(1'b0)) dut_min (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .MemReady(MemReady),
    .MemReq(n_memreq), .MemWrite(n_memwrite), .IRWrite(n_irwrite), .PCWrite(n_pcwrite),
    .AdrSrc(n_adrsrc), .ALUSrcA(n_srca), .ALUSrcB(n_srcb), .ResultSrc(n_ressrc),
    .ImmSrc(n_immsrc), .ALUControl(n_aluctl), .RegWrite(n_regwrite),
    .IllegalInstr(n_illegal)
  );

  assign obs_a = {MemReq, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ALUControl, RegWrite, IllegalInstr};
  assign obs_b = {n_memreq, n_memwrite, n_irwrite, n_pcwrite, n_adrsrc, n_srca, n_srcb,
                  n_ressrc, n_aluctl, n_regwrite, n_illegal};

  function automatic logic [16:0] bundle(input logic mreq, input logic mw, input logic irw,
                                         input logic pcw, input logic adr,
                                         input logic [1:0] srca, input logic [1:0] srcb,
                                         input logic [1:0] res, input logic [3:0] alu,
                                         input logic rw, input logic ill);
    return {mreq, mw, irw, pcw, adr, srca, srcb, res, alu, rw, ill};
  endfunction

  function automatic logic [16:0] reset_bundle();
    return bundle(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 4'd0, 0, 0);
  endfunction

  function automatic logic [6:0] opcode_of(input int cls);
    case (cls)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      C_AUIPC: return 7'b0010111;
      default: return 7'b0001111;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int cls);
    case (cls)
      C_SW:           return 3'b001;
      C_BR:           return 3'b010;
      C_JAL:          return 3'b011;
      C_LUI, C_AUIPC: return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  // ALU operation named by the instruction's mnemonic
  function automatic logic [3:0] alu_of(input int cls, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (cls == C_R && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Branch outcome straight from the operand values
  function automatic logic branch_outcome(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic legal(input int cls, input logic [2:0] f3, input logic en_br,
                                 input logic en_up);
    case (cls)
      C_LW, C_SW:     return f3 == 3'd2;
      C_JALR:         return f3 == 3'd0;
      C_BR:           return (f3 == 3'd0) || (en_br && (f3 == 3'd1 || f3 >= 3'd4));
      C_LUI, C_AUIPC: return en_up;
      C_BAD:          return 1'b0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [16:0] expect_phase(input int ph, input logic mr, input int cls,
                                               input logic [2:0] f3, input logic f7,
                                               input logic tk);
    case (ph)
      P_FETCH:    return bundle(1, 0, mr, mr, 0, 2'b00, 2'b10, 2'b10, 4'd0, 0, 0);
      P_DECODE:   return bundle(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'd0, 0, 0);
      P_MEMADR:   return bundle(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd0, 0, 0);
      P_MEMREAD:  return bundle(1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
      P_MEMWB:    return bundle(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'd0, 1, 0);
      P_MEMWRITE: return bundle(1, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
      P_EXECR:    return bundle(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, alu_of(cls, f3, f7), 0, 0);
      P_EXECI:    return bundle(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, alu_of(cls, f3, f7), 0, 0);
      P_ALUWB:    return bundle(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
      P_JALR:     return bundle(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd0, 0, 0);
      P_JAL:      return bundle(0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 4'd0, 0, 0);
      P_BRANCH:   return bundle(0, 0, 0, tk, 0, 2'b10, 2'b00, 2'b00, 4'd1, 0, 0);
      P_LUI:      return bundle(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 4'd0, 1, 0);
      default:    return bundle(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
    endcase
  endfunction

  // Drive one cycle's inputs at the falling edge; flags are those of a-b
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic [31:0] a, input logic [31:0] b, input logic mr);
    logic [32:0] d;
    @(negedge clk);
    d        = {1'b0, a} + {1'b0, ~b} + 33'd1;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = (d[31:0] == 32'd0);
    Neg      = d[31];
    Carry    = d[32];
    Ovf      = (a[31] != b[31]) && (d[31] != a[31]);
    MemReady = mr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int which, input logic [16:0] expv,
                             input logic [2:0] expimm);
    logic [16:0] o;
    logic [2:0]  im;
    o  = (which == 0) ? obs_a : obs_b;
    im = (which == 0) ? ImmSrc : n_immsrc;
    total++;
    assert (o === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s outputs observed=%05h expected=%05h", tag, o, expv);
    end
    total++;
    assert (im === expimm)
    else begin
      bad++;
      $error("[TB] FAIL %s immsrc observed=%0d expected=%0d", tag, im, expimm);
    end
  endtask

  // Hold reset across one rising edge, then release with MemReady low so
  // FETCH simply waits for the next instruction's stimulus
  task automatic resetAll();
    @(negedge clk);
    reset    = 1'b1;
    MemReady = 1'b0;
    op       = opcode_of(C_R);
    #1;
    checkOutput("reset_dut", 0, reset_bundle(), 3'b000);
    checkOutput("reset_min", 1, reset_bundle(), 3'b000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expand one instruction into its step list and check every cycle.
  // wf/wm are the MemReady=0 cycles inserted in fetch and data access.
  task automatic runInstr(input string tag, input int which, input int cls,
                          input logic [2:0] f3, input logic f7, input int wf, input int wm,
                          input logic [31:0] a, input logic [31:0] b);
    int   ph[$];
    int   w;
    logic lg, tk, mr;
    lg = legal(cls, f3, which == 0, which == 0);
    tk = branch_outcome(f3, a, b);
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    if (!lg) begin
      for (int i = 0; i < 10; i++) ph.push_back(P_TRAP);
    end else begin
      case (cls)
        C_R:     begin ph.push_back(P_EXECR); ph.push_back(P_ALUWB); end
        C_I:     begin ph.push_back(P_EXECI); ph.push_back(P_ALUWB); end
        C_LW:    begin ph.push_back(P_MEMADR); ph.push_back(P_MEMREAD); ph.push_back(P_MEMWB); end
        C_SW:    begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWRITE); end
        C_BR:    ph.push_back(P_BRANCH);
        C_JAL:   begin ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
        C_JALR:  begin ph.push_back(P_JALR); ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
        C_LUI:   ph.push_back(P_LUI);
        default: ph.push_back(P_ALUWB);
      endcase
    end
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH) w = wf;
      else if (ph[i] == P_MEMREAD || ph[i] == P_MEMWRITE) w = wm;
      else w = -1;
      if (w < 0) begin
        mr = 1'($urandom_range(0, 1));
        applyStimulus(opcode_of(cls), f3, f7, a, b, mr);
        checkOutput($sformatf("%s step%0d", tag, i), which,
                    expect_phase(ph[i], mr, cls, f3, f7, tk), imm_of(cls));
      end else begin
        for (int k = 0; k <= w; k++) begin
          mr = (k == w);
          applyStimulus(opcode_of(cls), f3, f7, a, b, mr);
          checkOutput($sformatf("%s step%0d wait%0d", tag, i, k), which,
                      expect_phase(ph[i], mr, cls, f3, f7, tk), imm_of(cls));
        end
      end
    end
    if (!lg) resetAll();
  endtask

  logic [31:0] pa[6];
  logic [31:0] pb[6];
  logic [2:0]  brf3[6];

  initial begin
    int          cls;
    logic [2:0]  f3;
    logic [31:0] ra, rb;

    pa   = '{32'd5, 32'd3, 32'd9, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    pb   = '{32'd5, 32'd9, 32'd3, 32'd1, 32'h8000_0000, 32'd0};
    brf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    reset    = 1'b1;
    op       = opcode_of(C_R);
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    Zero     = 1'b0;
    Neg      = 1'b0;
    Ovf      = 1'b0;
    Carry    = 1'b0;
    MemReady = 1'b0;
    #1;
    checkOutput("power_on_reset", 0, reset_bundle(), 3'b000);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] add x3,x1,x2 / sub / lw with waits");
    runInstr("add", 0, C_R, 3'd0, 1'b0, 0, 0, 32'd1, 32'd2);
    runInstr("sub", 0, C_R, 3'd0, 1'b1, 0, 0, 32'd1, 32'd2);
    runInstr("addi_b30", 0, C_I, 3'd0, 1'b1, 0, 0, 32'd1, 32'd2);
    runInstr("srai", 0, C_I, 3'd5, 1'b1, 0, 0, 32'd1, 32'd2);
    runInstr("lw_wait", 0, C_LW, 3'd2, 1'b0, 0, 2, 32'd0, 32'd0);
    runInstr("sw_wait", 0, C_SW, 3'd2, 1'b0, 1, 1, 32'd0, 32'd0);

    $display("[TB] branch sweep");
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 6; p++) begin
        runInstr($sformatf("br f3=%0d p%0d", brf3[f], p), 0, C_BR, brf3[f], 1'b0, 0, 0,
                 pa[p], pb[p]);
      end
    end

    $display("[TB] jalr then lui, jal, auipc");
    runInstr("jalr", 0, C_JALR, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("lui", 0, C_LUI, 3'd3, 1'b1, 0, 0, 32'd0, 32'd0);
    runInstr("jal", 0, C_JAL, 3'd6, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("auipc", 0, C_AUIPC, 3'd1, 1'b0, 0, 0, 32'd0, 32'd0);

    $display("[TB] illegal encodings on default build");
    runInstr("lb_trap", 0, C_LW, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("jalr_f3_trap", 0, C_JALR, 3'd1, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("br_f3_2_trap", 0, C_BR, 3'd2, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("fence_trap", 0, C_BAD, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);

    $display("[TB] reduced build");
    resetAll();
    runInstr("min_beq", 1, C_BR, 3'd0, 1'b0, 0, 0, 32'd7, 32'd7);
    runInstr("min_bne_trap", 1, C_BR, 3'd1, 1'b0, 0, 0, 32'd7, 32'd8);
    runInstr("min_lui_trap", 1, C_LUI, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("min_auipc_trap", 1, C_AUIPC, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
    runInstr("min_add", 1, C_R, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);

    $display("[TB] async reset during store wait");
    resetAll();
    applyStimulus(opcode_of(C_SW), 3'd2, 1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("rst_sw fetch", 0, expect_phase(P_FETCH, 1'b1, C_SW, 3'd2, 1'b0, 1'b0), 3'b001);
    applyStimulus(opcode_of(C_SW), 3'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("rst_sw decode", 0, expect_phase(P_DECODE, 1'b0, C_SW, 3'd2, 1'b0, 1'b0), 3'b001);
    applyStimulus(opcode_of(C_SW), 3'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("rst_sw memadr", 0, expect_phase(P_MEMADR, 1'b0, C_SW, 3'd2, 1'b0, 1'b0), 3'b001);
    applyStimulus(opcode_of(C_SW), 3'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("rst_sw memwrite", 0, expect_phase(P_MEMWRITE, 1'b0, C_SW, 3'd2, 1'b0, 1'b0), 3'b001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_sw during_reset", 0, reset_bundle(), 3'b001);
    total++;
    assert (MemWrite === 1'b0)
    else begin
      bad++;
      $error("[TB] FAIL rst_sw memwrite_drop observed=%b expected=0", MemWrite);
    end
    @(negedge clk);
    #1;
    checkOutput("rst_sw held_reset", 0, reset_bundle(), 3'b001);
    reset    = 1'b0;
    MemReady = 1'b0;
    runInstr("after_reset_add", 0, C_R, 3'd7, 1'b0, 0, 0, 32'd0, 32'd0);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 8);
      f3  = 3'($urandom_range(0, 7));
      if (cls == C_LW || cls == C_SW) f3 = 3'd2;
      if (cls == C_JALR) f3 = 3'd0;
      if (cls == C_BR) f3 = brf3[$urandom_range(0, 5)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      runInstr($sformatf("rnd%0d cls%0d", n, cls), 0, cls, f3, 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
